// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared state encoding and frame constants for the program loader
package prog_loader_pkg;
  typedef enum logic [2:0] {IDLE, LEN, HI, LO, WR, CHK} state_t;
  localparam logic [7:0] HDR_DEF = 8'hA5;
  localparam logic [8:0] LEN_MAX = 9'd256;
endpackage

// File: rtl/prog_loader.sv
// prog_loader: byte-stream frame loader writing 16-bit words into imem while holding the CPU
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int          ADDR_W = 8,
  parameter logic [7:0]  HDR    = HDR_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_wren,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);
  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [8:0]        rem;
  logic [7:0]        sum;
  logic [7:0]        hi;
  logic              xfer;
  assign in_ready = state != WR;
  assign cpu_hold = state != IDLE;
  assign xfer     = in_valid && in_ready;
  // frame parser; the write strobe and its address/data are registered on low-byte acceptance
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      addr      <= '0;
      rem       <= '0;
      sum       <= '0;
      hi        <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wren  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_wren <= 1'b0;
      case (state)
        IDLE: if (xfer && in_data == HDR) begin
          state <= LEN;
          done  <= 1'b0;
          err   <= 1'b0;
          addr  <= '0;
          sum   <= '0;
        end
        LEN: if (xfer) begin
          rem   <= in_data == 8'd0 ? LEN_MAX : {1'b0, in_data};
          state <= HI;
        end
        HI: if (xfer) begin
          hi    <= in_data;
          sum   <= sum + in_data;
          state <= LO;
        end
        LO: if (xfer) begin
          sum       <= sum + in_data;
          mem_addr  <= addr;
          mem_wdata <= {hi, in_data};
          mem_wren  <= 1'b1;
          state     <= WR;
        end
        WR: begin
          addr  <= addr + ADDR_W'(1);
          rem   <= rem - 9'd1;
          state <= rem == 9'd1 ? CHK : HI;
        end
        CHK: if (xfer) begin
          err   <= in_data != sum;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: table-driven frame tests with a write scoreboard on two address widths
module tb_prog_loader;
  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready, in_ready2;
  logic [7:0]  mem_addr;
  logic [1:0]  mem_addr2;
  logic [15:0] mem_wdata, mem_wdata2;
  logic        mem_wren, mem_wren2;
  logic        cpu_hold, cpu_hold2;
  logic        done, done2;
  logic        err, err2;
  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int t_acc = 0;
  int nw8 = 0;
  logic [7:0]  qa8[$], qa2[$];
  logic [15:0] qd8[$], qd2[$];
  logic [15:0] mem8[256];
  logic [15:0] mem2[4];
  typedef struct {
    logic [7:0]  len;
    logic [15:0] base;
    logic [15:0] step;
    bit          bad;
    bit          gaps;
    bit          garb;
    bit          exp_err;
  } vec_t;
  vec_t vecs[7];

  prog_loader #(.ADDR_W(8)) dut (
    .CLK(CLK), .RST(RST), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );
  prog_loader #(.ADDR_W(2)) dut2 (
    .CLK(CLK), .RST(RST), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready2),
    .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_wren(mem_wren2),
    .cpu_hold(cpu_hold2), .done(done2), .err(err2)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // imem-side monitor: every write must match the next scoreboard entry; ready drops only in WR
  always @(negedge CLK) if (!RST) begin
    chk("ready_vs_wr", {31'd0, in_ready}, {31'd0, !mem_wren});
    chk("ready_vs_wr2", {31'd0, in_ready2}, {31'd0, !mem_wren2});
    if (mem_wren) begin
      if (qa8.size() == 0) chk("unexpected_wr8", 32'd1, 32'd0);
      else begin
        chk("wr8_addr", {24'd0, mem_addr}, {24'd0, qa8.pop_front()});
        chk("wr8_data", {16'd0, mem_wdata}, {16'd0, qd8.pop_front()});
      end
      mem8[mem_addr] = mem_wdata;
      nw8++;
    end
    if (mem_wren2) begin
      if (qa2.size() == 0) chk("unexpected_wr2", 32'd1, 32'd0);
      else begin
        chk("wr2_addr", {30'd0, mem_addr2}, {24'd0, qa2.pop_front()});
        chk("wr2_data", {16'd0, mem_wdata2}, {16'd0, qd2.pop_front()});
      end
      mem2[mem_addr2] = mem_wdata2;
    end
  end

  task automatic send(input logic [7:0] b, input bit g);
    int k = 0;
    int gp = g ? int'($urandom_range(0, 3)) : 0;
    repeat (gp) begin
      in_valid = 1'b0;
      in_data = 8'($urandom);
      @(negedge CLK);
    end
    in_data = b;
    in_valid = 1'b1;
    while (!in_ready && k < 8) begin
      @(negedge CLK);
      k++;
    end
    if (!in_ready) chk("send_stall_bound", 32'd0, 32'd1);
    @(negedge CLK);
    t_acc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic frame(input vec_t v);
    int n = v.len == 8'd0 ? 256 : int'(v.len);
    logic [7:0] s = 8'd0;
    logic [15:0] w;
    int t0;
    int w0;
    for (int i = 0; i < n; i++) begin
      w = v.base + 16'(v.step * i);
      qa8.push_back(8'(i));
      qa2.push_back({6'd0, 2'(i)});
      qd8.push_back(w);
      qd2.push_back(w);
      s = s + w[15:8] + w[7:0];
    end
    if (v.garb) begin
      send(8'h00, v.gaps); chk("garb_hold0", {31'd0, cpu_hold}, 32'd0);
      send(8'hFF, v.gaps); chk("garb_hold1", {31'd0, cpu_hold}, 32'd0);
      send(8'h5A, v.gaps); chk("garb_hold2", {31'd0, cpu_hold}, 32'd0);
    end
    w0 = nw8;
    send(8'hA5, v.gaps);
    t0 = t_acc;
    chk("hdr_hold", {31'd0, cpu_hold}, 32'd1);
    chk("hdr_done_clr", {31'd0, done}, 32'd0);
    chk("hdr_err_clr", {31'd0, err}, 32'd0);
    send(v.len, v.gaps);
    for (int i = 0; i < n; i++) begin
      w = v.base + 16'(v.step * i);
      send(w[15:8], v.gaps);
      send(w[7:0], v.gaps);
    end
    send(v.bad ? 8'h00 : s, v.gaps);
    if (!v.gaps) chk("frame_cycles", t_acc - t0 + 1, 3 + 3 * n);
    chk("end_done", {31'd0, done}, 32'd1);
    chk("end_err", {31'd0, err}, {31'd0, v.exp_err});
    chk("end_hold", {31'd0, cpu_hold}, 32'd0);
    chk("end_done2", {31'd0, done2}, 32'd1);
    chk("wr_count", nw8 - w0, n);
  endtask

  task automatic chk_reset_vals();
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_addr", {24'd0, mem_addr}, 32'd0);
    chk("rst_wdata", {16'd0, mem_wdata}, 32'd0);
    chk("rst_wren", {31'd0, mem_wren}, 32'd0);
    chk("rst_hold", {31'd0, cpu_hold}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{8'd2, 16'h1234, 16'h9999, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'd2, 16'h1234, 16'h9999, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{8'd1, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'd0, 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{8'd5, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{8'd3, 16'hA5A5, 16'h0101, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{8'd2, 16'h1234, 16'h9999, 1'b0, 1'b1, 1'b0, 1'b0};
    RST = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (3) @(negedge CLK);
    chk_reset_vals();
    RST = 1'b0;
    @(negedge CLK);
    chk_reset_vals();
    for (int v = 0; v < 7; v++) begin
      frame(vecs[v]);
      if (v == 0) begin
        chk("basic_m0", {16'd0, mem8[0]}, 32'h1234);
        chk("basic_m1", {16'd0, mem8[1]}, 32'hABCD);
      end
      if (v == 3) chk("len0_m255", {16'd0, mem8[255]}, 32'h00FF);
      if (v == 4) begin
        chk("wrap_m0", {16'd0, mem2[0]}, 32'd5);
        chk("wrap_m1", {16'd0, mem2[1]}, 32'd2);
        chk("wrap_m3", {16'd0, mem2[3]}, 32'd4);
        chk("wrap_err2", {31'd0, err2}, 32'd0);
      end
    end
    send(8'hA5, 1'b0);
    send(8'h03, 1'b0);
    send(8'h11, 1'b0);
    chk("pre_rst_hold", {31'd0, cpu_hold}, 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    chk_reset_vals();
    RST = 1'b0;
    @(negedge CLK);
    frame(vecs[0]);
    chk("post_rst_m1", {16'd0, mem8[1]}, 32'hABCD);
    chk("queue_empty8", qa8.size(), 0);
    chk("queue_empty2", qa2.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
